// File: rtl/result_demux_2way_pkg.sv
// Shared types and widths for the 2-way result demultiplexer.
package result_demux_2way_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage : result_demux_2way_pkg

// File: rtl/result_demux_2way_out_slot_reg.sv
// One-entry output register with valid/ready handshake and a delivered-word counter.
module out_slot_reg
  import result_demux_2way_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drain;

  assign drain = (state_q == SLOT_FULL) && ready_i;

  // A load wins over a drain so back-to-back words stream at one per cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = load_data_i;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
    if (drain) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule : out_slot_reg

// File: rtl/result_demux_2way.sv
// Buffered 1-to-2 demux: routes each accepted word to one of two independent output slots.
module result_demux_2way
  import result_demux_2way_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  logic accept;
  logic load0, load1;

  // Only the selected slot's occupancy gates acceptance; the other slot never stalls input.
  assign in_ready = in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !in_sel;
  assign load1    = accept && in_sel;

  out_slot_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load0),
    .load_data_i (in_data),
    .ready_i     (out0_ready),
    .valid_o     (out0_valid),
    .data_o      (out0_data),
    .count_o     (out0_count)
  );

  out_slot_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load1),
    .load_data_i (in_data),
    .ready_i     (out1_ready),
    .valid_o     (out1_valid),
    .data_o      (out1_data),
    .count_o     (out1_count)
  );

endmodule : result_demux_2way

// File: tb/tb_result_demux_2way.sv
// Directed plus randomized bench for result_demux_2way against a queue-based destination model.
module tb_result_demux_2way;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  out0_count;
  logic [7:0]  out1_count;

  int unsigned total;
  int unsigned bad;

  // Model: each destination is a FIFO of capacity one plus a delivered-word tally.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int unsigned delivered0;
  int unsigned delivered1;

  result_demux_2way dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    if (in_sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  task automatic check_all();
    chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
    chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
    chk("out0_count", 32'(out0_count), 32'(8'(delivered0)));
    chk("out1_count", 32'(out1_count), 32'(8'(delivered1)));
  endtask

  // Apply inputs away from the edge, then check the combinational ready.
  task automatic drive(input logic v, input logic sel, input logic [15:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    chk("sel_known", 32'(in_valid && $isunknown(in_sel)), 32'd0);
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
  endtask

  // Advance one clock, update the model with what the edge should do, then compare.
  task automatic tick();
    logic acc;
    acc = in_valid && model_ready();
    if (q0.size() != 0 && out0_ready) begin
      void'(q0.pop_front());
      delivered0++;
    end
    if (q1.size() != 0 && out1_ready) begin
      void'(q1.pop_front());
      delivered1++;
    end
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    delivered0 = 0;
    delivered1 = 0;
  endtask

  initial begin
    int unsigned c_before;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_reset();

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single route to out1 with a 5-cycle hold
    drive(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    tick();
    chk("route_out1_data", 32'(out1_data), 32'h0000BEEF);
    chk("route_out0_valid", 32'(out0_valid), 32'd0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out1_data", 32'(out1_data), 32'h0000BEEF);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();
    chk("drain_out1_count", 32'(out1_count), 32'd1);
    chk("drain_out1_valid", 32'(out1_valid), 32'd0);

    // Back-pressure isolation
    drive(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
    chk("bp_stall", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 16'h0002, 1'b0, 1'b0);
    chk("bp_other_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_out1_data", 32'(out1_data), 32'h00000002);
    chk("bp_out0_data", 32'(out0_data), 32'h00000001);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    tick();

    // Streaming 1..10 to out0
    c_before = delivered0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
      chk("stream_ready", 32'(in_ready), 32'd1);
      tick();
      chk("stream_data", 32'(out0_data), 32'(i));
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("stream_count", 32'(out0_count), 32'(8'(c_before + 10)));

    // Simultaneous drain and load on slot1
    drive(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    tick();
    c_before = delivered1;
    drive(1'b1, 1'b1, 16'h5555, 1'b0, 1'b1);
    chk("dl_ready", 32'(in_ready), 32'd1);
    tick();
    chk("dl_valid", 32'(out1_valid), 32'd1);
    chk("dl_data", 32'(out1_data), 32'h00005555);
    chk("dl_count", 32'(out1_count), 32'(8'(c_before + 1)));
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();

    // Mid-operation reset with slot0 full
    drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mrst_out0_valid", 32'(out0_valid), 32'd0);
    chk("mrst_out0_data", 32'(out0_data), 32'd0);
    chk("mrst_out0_count", 32'(out0_count), 32'd0);
    chk("mrst_out1_count", 32'(out1_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);

    // Put one word through out1 so the wrap check also proves out1 is untouched
    drive(1'b1, 1'b1, 16'h7777, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    tick();

    // Counter wrap: 256 out0 handshakes
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    chk("wrap_out0_count", 32'(out0_count), 32'd0);
    chk("wrap_out1_count", 32'(out1_count), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_result_demux_2way
